flt_result_capture: RTL
=======================

FLT_RESULT_CAPTURE -- requirements
Module: flt_result_capture

Interface
REQ-001 Parameter WIDTH, default 32, bit width of one float operand/result word.
REQ-002 Parameter DEPTH, default 16, number of entries in the capture FIFO (power of two).
REQ-003 Parameter CAPTURE_LEN, default 64, number of result beats captured per run.
REQ-004 The block SHALL use one clock, i_aclk, and an asynchronous, active-high reset, i_areset; the polarity and synchronicity of i_areset are fixed.
REQ-005 Port list (name  direction  width  meaning):
- i_aclk  in  1  clock.
- i_areset  in  1  async active-high reset.
- i_start  in  1  one-cycle pulse; arms a capture run.
- i_axi4s_result_tdata  in  WIDTH  result word from the float core.
- i_axi4s_a_tdata  in  WIDTH  operand delay-aligned with the result.
- i_axi4s_result_tvalid  in  1  result beat valid.
- o_axi4s_result_tready  out  1  block accepts the result beat.
- o_axi4s_byte_tdata  out  8  serialized byte stream.
- o_axi4s_byte_tvalid  out  1  byte valid.
- i_axi4s_byte_tready  in  1  downstream accepts the byte.
- o_axi4s_byte_tlast  out  1  last byte of the last entry of a run.
- o_busy  out  1  FSM is not in IDLE.
- o_count  out  16  entries accepted in the current run.

Function
REQ-006 The FSM SHALL have four states: IDLE, CAPTURE, DRAIN and DONE.
REQ-007 Transitions: IDLE->CAPTURE on i_start; CAPTURE->DRAIN when o_count reaches CAPTURE_LEN; DRAIN->DONE when the tlast byte handshakes; DONE->IDLE on the next cycle.
REQ-008 i_start SHALL be ignored outside IDLE.
REQ-009 A beat SHALL be accepted when i_axi4s_result_tvalid and o_axi4s_result_tready are both high in a cycle.
REQ-010 o_axi4s_result_tready SHALL be high only in CAPTURE with the FIFO not full; its value SHALL not depend combinationally on tvalid.
REQ-011 Each accepted beat SHALL write the entry {i_axi4s_a_tdata, i_axi4s_result_tdata} (2*WIDTH bits) to the FIFO.
REQ-012 Each accepted beat SHALL increment o_count by 1; o_count SHALL clear to 0 when a run starts (IDLE->CAPTURE).
REQ-013 The FIFO SHALL be synchronous and show-ahead, with write->read latency of 1 cycle; a simultaneous write and read when full or empty SHALL be legal, and occupancy SHALL be unchanged when both occur.
REQ-014 The serializer SHALL run in both CAPTURE and DRAIN: it loads the FIFO head when idle and the FIFO is non-empty, then presents o_axi4s_byte_tvalid from the next cycle.
REQ-015 Byte order per entry SHALL be 2*WIDTH/8 bytes: operand MSB first, then result MSB first.
REQ-016 The byte output SHALL advance only on a tvalid&&tready handshake; tdata SHALL hold stable while tvalid=1 and tready=0.
REQ-017 o_axi4s_byte_tlast SHALL assert only on the final byte of entry number CAPTURE_LEN.
REQ-018 Back-to-back entries SHALL stream with no idle cycle when the FIFO is non-empty.
REQ-019 Input beats arriving outside CAPTURE SHALL be ignored, with tready=0 and no FIFO write.
REQ-020 Arithmetic: o_count SHALL saturate at 16'hFFFF; the byte index SHALL wrap from the last byte to 0.

Reset
REQ-021 On i_areset, the FSM SHALL go to IDLE and the FIFO pointers SHALL be cleared to empty.
REQ-022 On i_areset, o_axi4s_result_tready=0, o_axi4s_byte_tvalid=0, o_axi4s_byte_tlast=0, o_axi4s_byte_tdata=0, o_busy=0 and o_count=0.
REQ-023 Reset asserted mid-run SHALL discard all buffered entries and any partial byte sequence; after release, no byte SHALL be emitted until a new i_start.

Structure
REQ-024 Package flt_capture_pkg SHALL hold the FSM state enum, the default WIDTH/DEPTH/CAPTURE_LEN values, and the bytes-per-entry constant.
REQ-025 The FIFO SHALL be a separate sub-module, flt_capture_fifo; the FSM, counter and serializer SHALL stay in the top level.

Verification
REQ-026 CAPTURE_LEN=1; operand 0x40000000, result 0x3F000000; byte tready held 1 -> bytes 40 00 00 00 3F 00 00 00 on consecutive cycles, tlast on the 8th byte, then DONE then IDLE.
REQ-027 CAPTURE_LEN=64; tvalid held 1; byte tready=0 throughout -> exactly 16+1 beats accepted, then tready=0, o_count=17, FIFO full, no overflow.
REQ-028 Byte tready toggling 1010...; operand 0x3F800000, result 0x3F800000 -> byte tdata stable during stalls, 8 bytes correct, no drops or duplicates.
REQ-029 Tvalid pulses before i_start -> tready=0, o_count=0, no bytes; after i_start, the first accepted beat is the first entry emitted.
REQ-030 i_areset asserted after 5 accepted beats and 3 bytes emitted -> all outputs at reset values immediately; after release and a new i_start, the first byte is the MSB of the new operand.

Source files
------------

// File: rtl/flt_capture_pkg.sv
// Shared types and defaults for the float result capture block.
package flt_capture_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned DefWidth      = 32;
  localparam int unsigned DefDepth      = 16;
  localparam int unsigned DefCaptureLen = 64;

  // One FIFO entry is {operand, result}, serialized a byte at a time.
  function automatic int unsigned bytes_per_entry(input int unsigned width);
    return (2 * width) / 8;
  endfunction

  localparam int unsigned DefBytesPerEntry = (2 * DefWidth) / 8;

endpackage

// File: rtl/flt_capture_fifo.sv
// Synchronous show-ahead FIFO: a written entry is visible on rdata_o the next cycle.
module flt_capture_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             rd_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw:0]      wptr_q, wptr_d;
  logic [Aw:0]      rptr_q, rptr_d;
  logic             do_wr, do_rd;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);

  // Write+read together is allowed at both boundaries and leaves occupancy unchanged.
  assign do_wr = wr_i && (!full_o || rd_i);
  assign do_rd = rd_i && (!empty_o || wr_i);

  // When empty, a same-cycle read takes the incoming word directly.
  assign rdata_o = empty_o ? wdata_i : mem_q[rptr_q[Aw-1:0]];

  // Pointer next-state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_wr) wptr_d = wptr_q + 1'b1;
    if (do_rd) rptr_d = rptr_q + 1'b1;
  end

  // Pointer registers; cleared to empty on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q[Aw-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/flt_result_capture.sv
// Captures a run of float results with their operands and streams them out as bytes.
module flt_result_capture
  import flt_capture_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned DEPTH       = DefDepth,
  parameter int unsigned CAPTURE_LEN = DefCaptureLen
) (
  input  logic             i_aclk,
  input  logic             i_areset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_axi4s_result_tdata,
  input  logic [WIDTH-1:0] i_axi4s_a_tdata,
  input  logic             i_axi4s_result_tvalid,
  output logic             o_axi4s_result_tready,
  output logic [7:0]       o_axi4s_byte_tdata,
  output logic             o_axi4s_byte_tvalid,
  input  logic             i_axi4s_byte_tready,
  output logic             o_axi4s_byte_tlast,
  output logic             o_busy,
  output logic [15:0]      o_count
);

  localparam int unsigned EntryW  = 2 * WIDTH;
  localparam int unsigned Bpe     = bytes_per_entry(WIDTH);
  localparam int unsigned IdxW    = $clog2(Bpe);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Bpe - 1);
  localparam logic [15:0]     CapLen  = 16'(CAPTURE_LEN);

  state_e              state_q, state_d;
  logic [15:0]         count_q, count_d;
  logic [15:0]         ent_q, ent_d;     // number of the entry held in the serializer
  logic [EntryW-1:0]   sh_q, sh_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                bvalid_q, bvalid_d;

  logic                fifo_full, fifo_empty, fifo_rd;
  logic [EntryW-1:0]   fifo_rdata;
  logic                run, accept, byte_hs, last_byte, start_run;

  assign run       = (state_q == StCapture) || (state_q == StDrain);
  assign start_run = (state_q == StIdle) && i_start;
  // Stop accepting once the run length is reached so no extra beat slips in.
  assign o_axi4s_result_tready = (state_q == StCapture) && !fifo_full && (count_q != CapLen);
  assign accept    = i_axi4s_result_tvalid && o_axi4s_result_tready;
  assign byte_hs   = bvalid_q && i_axi4s_byte_tready;
  assign last_byte = (idx_q == LastIdx);
  // Reload on the final byte's handshake so entries stream back to back.
  assign fifo_rd   = run && !fifo_empty && (!bvalid_q || (byte_hs && last_byte));

  assign o_axi4s_byte_tdata  = sh_q[EntryW-1 -: 8];
  assign o_axi4s_byte_tvalid = bvalid_q;
  assign o_axi4s_byte_tlast  = bvalid_q && last_byte && (ent_q == CapLen);
  assign o_busy              = (state_q != StIdle);
  assign o_count             = count_q;

  flt_capture_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (i_aclk),
    .rst_i   (i_areset),
    .wr_i    (accept),
    .wdata_i ({i_axi4s_a_tdata, i_axi4s_result_tdata}),
    .rd_i    (fifo_rd),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Run sequencing: IDLE -> CAPTURE -> DRAIN -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (i_start) state_d = StCapture;
      StCapture: if (count_q == CapLen) state_d = StDrain;
      StDrain:   if (byte_hs && o_axi4s_byte_tlast) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Accepted-beat and loaded-entry counters, both saturating and cleared at run start.
  always_comb begin
    count_d = count_q;
    ent_d   = ent_q;
    if (start_run) begin
      count_d = '0;
      ent_d   = '0;
    end else begin
      if (accept && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
      if (fifo_rd && (ent_q != 16'hFFFF))  ent_d   = ent_q + 16'd1;
    end
  end

  // Serializer: shift out MSB byte first, load a fresh entry when free.
  always_comb begin
    sh_d     = sh_q;
    idx_d    = idx_q;
    bvalid_d = bvalid_q;
    if (byte_hs) begin
      sh_d  = sh_q << 8;
      idx_d = last_byte ? '0 : idx_q + 1'b1;
      if (last_byte) bvalid_d = 1'b0;
    end
    if (fifo_rd) begin
      sh_d     = fifo_rdata;
      idx_d    = '0;
      bvalid_d = 1'b1;
    end
  end

  // State registers; reset discards any partial byte sequence.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      ent_q    <= '0;
      sh_q     <= '0;
      idx_q    <= '0;
      bvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ent_q    <= ent_d;
      sh_q     <= sh_d;
      idx_q    <= idx_d;
      bvalid_q <= bvalid_d;
    end
  end

endmodule
